// File: rtl/freq_sweep_pkg.sv
// Shared types and defaults for the frequency sweeper.
// Holds the FSM state enum, sweep direction encoding and width defaults.
package freq_sweep_pkg;

    localparam int PARAM_W_DEF = 8;
    localparam int DWELL_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        STEP  = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef enum logic {
        DIR_UP = 1'b0,
        DIR_DN = 1'b1
    } dir_e;

endpackage

// File: rtl/dwell_timer.sv
// Dwell counter: counts enabled cycles and flags the last one of a dwell.
// Clear has priority over enable; len_i must be at least 1.
module dwell_timer
    import freq_sweep_pkg::*;
#(
    parameter int DWELL_W = DWELL_W_DEF
) (
    input  logic               clk_in,
    input  logic               rst,
    input  logic               clr_i,
    input  logic               en_i,
    input  logic [DWELL_W-1:0] len_i,
    output logic               tc_o
);

    logic [DWELL_W-1:0] cnt_q;
    logic [DWELL_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + DWELL_W'(1);
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = en_i && (cnt_q == (len_i - DWELL_W'(1)));

endmodule

// File: rtl/freq_sweeper.sv
// Frequency sweeper: steps a code between lo and hi, holding each for a
// dwell period, as a one-shot up-ramp or a continuous triangle.
module freq_sweeper
    import freq_sweep_pkg::*;
#(
    parameter int PARAM_W = PARAM_W_DEF,
    parameter int DWELL_W = DWELL_W_DEF
) (
    input  logic               clk_in,
    input  logic               rst,
    input  logic               start,
    input  logic               stop_req,
    input  logic [PARAM_W-1:0] sweep_lo,
    input  logic [PARAM_W-1:0] sweep_hi,
    input  logic [PARAM_W-1:0] step,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               mode,
    output logic [PARAM_W-1:0] freq_param,
    output logic               param_upd,
    output logic               busy,
    output logic               done,
    output logic               cfg_err
);

    state_e             state_q, state_d;
    dir_e               dir_q, dir_d;
    logic [PARAM_W-1:0] freq_q, freq_d;
    logic [PARAM_W-1:0] lo_q, lo_d;
    logic [PARAM_W-1:0] hi_q, hi_d;
    logic [PARAM_W-1:0] step_q, step_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               mode_q, mode_d;
    logic               upd_q, upd_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic [PARAM_W:0]   up_sum, dn_diff;
    logic [PARAM_W-1:0] up_sat, dn_sat;
    logic               tc;

    dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_timer (
        .clk_in (clk_in),
        .rst    (rst),
        .clr_i  (state_q != DWELL),
        .en_i   (state_q == DWELL),
        .len_i  (dwell_q),
        .tc_o   (tc)
    );

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        freq_d  = freq_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        step_d  = step_q;
        dwell_d = dwell_q;
        mode_d  = mode_q;
        upd_d   = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;

        // One extra bit lets the saturation tests see carry and borrow.
        up_sum  = {1'b0, freq_q} + {1'b0, step_q};
        dn_diff = {1'b0, freq_q} - {1'b0, step_q};
        up_sat  = (up_sum > {1'b0, hi_q}) ? hi_q : up_sum[PARAM_W-1:0];
        dn_sat  = (dn_diff[PARAM_W] || (dn_diff[PARAM_W-1:0] < lo_q))
                ? lo_q : dn_diff[PARAM_W-1:0];

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (sweep_lo <= sweep_hi) begin
                        lo_d    = sweep_lo;
                        hi_d    = sweep_hi;
                        step_d  = (step == '0) ? PARAM_W'(1) : step;
                        dwell_d = (dwell == '0) ? DWELL_W'(1) : dwell;
                        mode_d  = mode;
                        dir_d   = DIR_UP;
                        freq_d  = sweep_lo;
                        upd_d   = 1'b1;
                        state_d = DWELL;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            DWELL: begin
                if (stop_req) begin
                    state_d = IDLE;
                end else if (tc) begin
                    state_d = STEP;
                end
            end
            STEP: begin
                if (stop_req) begin
                    state_d = IDLE;
                end else begin
                    state_d = DWELL;
                    if (dir_q == DIR_UP) begin
                        if (freq_q == hi_q) begin
                            if (mode_q) begin
                                dir_d  = DIR_DN;
                                freq_d = dn_sat;
                            end else begin
                                state_d = DONE;
                            end
                        end else begin
                            freq_d = up_sat;
                        end
                    end else begin
                        if (freq_q == lo_q) begin
                            dir_d  = DIR_UP;
                            freq_d = up_sat;
                        end else begin
                            freq_d = dn_sat;
                        end
                    end
                    upd_d = (freq_d != freq_q);
                end
            end
            DONE: begin
                state_d = IDLE;
                done_d  = !stop_req;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            dir_q   <= DIR_UP;
            freq_q  <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            step_q  <= '0;
            dwell_q <= '0;
            mode_q  <= 1'b0;
            upd_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            freq_q  <= freq_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            step_q  <= step_d;
            dwell_q <= dwell_d;
            mode_q  <= mode_d;
            upd_q   <= upd_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign freq_param = freq_q;
    assign param_upd  = upd_q;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign cfg_err    = err_q;

endmodule

// File: tb/tb_freq_sweeper.sv
// Directed bench for freq_sweeper: per-cycle vector tables plus
// hand-written sequences for triangle, config error and reset cases.
module tb_freq_sweeper;

    logic        clk_in = 1'b0;
    logic        rst;
    logic        start;
    logic        stop_req;
    logic [7:0]  sweep_lo;
    logic [7:0]  sweep_hi;
    logic [7:0]  step;
    logic [15:0] dwell;
    logic        mode;
    logic [7:0]  freq_param;
    logic        param_upd;
    logic        busy;
    logic        done;
    logic        cfg_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       start;
        logic       stop;
        logic [7:0] f;
        logic       upd;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t tbl[$];

    freq_sweeper dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .start      (start),
        .stop_req   (stop_req),
        .sweep_lo   (sweep_lo),
        .sweep_hi   (sweep_hi),
        .step       (step),
        .dwell      (dwell),
        .mode       (mode),
        .freq_param (freq_param),
        .param_upd  (param_upd),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic cfg(input int lo, input int hi, input int st,
                       input int dw, input logic md);
        sweep_lo = 8'(lo);
        sweep_hi = 8'(hi);
        step     = 8'(st);
        dwell    = 16'(dw);
        mode     = md;
    endtask

    task automatic add(input logic s, input logic p, input int f,
                       input logic u, input logic b, input logic d);
        vec_t v;
        v.start = s;
        v.stop  = p;
        v.f     = 8'(f);
        v.upd   = u;
        v.busy  = b;
        v.done  = d;
        tbl.push_back(v);
    endtask

    task automatic run_tbl(input string nm);
        for (int i = 0; i < tbl.size(); i++) begin
            start    = tbl[i].start;
            stop_req = tbl[i].stop;
            tick();
            start    = 1'b0;
            stop_req = 1'b0;
            chk($sformatf("%s[%0d].freq", nm, i), freq_param, tbl[i].f);
            chk($sformatf("%s[%0d].upd", nm, i), param_upd, tbl[i].upd);
            chk($sformatf("%s[%0d].busy", nm, i), busy, tbl[i].busy);
            chk($sformatf("%s[%0d].done", nm, i), done, tbl[i].done);
        end
        tbl.delete();
    endtask

    task automatic wait_upd(output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        for (int k = 0; k < 8 && !ok; k++) begin
            tick();
            n++;
            if (param_upd) ok = 1'b1;
        end
    endtask

    int tri_exp[8] = '{100, 200, 255, 155, 55, 0, 100, 200};
    int n;
    bit ok;

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        stop_req = 1'b0;
        cfg(0, 0, 0, 0, 1'b0);
        tick();
        tick();
        chk("rst.freq", freq_param, 0);
        chk("rst.upd", param_upd, 0);
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.err", cfg_err, 0);
        rst = 1'b0;
        tick();

        // One-shot ramp 10..40 step 10, dwell 3
        cfg(10, 40, 10, 3, 1'b0);
        add(1, 0, 10, 1, 1, 0);
        for (int c = 0; c < 3; c++) add(0, 0, 10, 0, 1, 0);
        for (int k = 2; k <= 4; k++) begin
            add(0, 0, k * 10, 1, 1, 0);
            for (int c = 0; c < 3; c++) add(0, 0, k * 10, 0, 1, 0);
        end
        add(0, 0, 40, 0, 1, 0);
        add(0, 0, 40, 0, 0, 1);
        add(0, 0, 40, 0, 0, 0);
        run_tbl("ramp");

        // Rejected config: lo > hi
        cfg(50, 20, 1, 1, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("cfgerr.pulse", cfg_err, 1);
        chk("cfgerr.busy", busy, 0);
        chk("cfgerr.freq", freq_param, 40);
        chk("cfgerr.upd", param_upd, 0);
        tick();
        chk("cfgerr.clear", cfg_err, 0);
        chk("cfgerr.idle", busy, 0);

        // step=0/dwell=0 must match step=1/dwell=1; start beats stop
        for (int r = 0; r < 2; r++) begin
            cfg(5, 7, r, r, 1'b0);
            add(1, 1, 5, 1, 1, 0);
            add(0, 0, 5, 0, 1, 0);
            add(0, 0, 6, 1, 1, 0);
            add(0, 0, 6, 0, 1, 0);
            add(0, 0, 7, 1, 1, 0);
            add(0, 0, 7, 0, 1, 0);
            add(0, 0, 7, 0, 1, 0);
            add(0, 0, 7, 0, 0, 1);
            add(0, 0, 7, 0, 0, 0);
            run_tbl(r == 0 ? "min0" : "min1");
        end

        // Triangle over full range, no wrap
        cfg(0, 255, 100, 1, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("tri.load", freq_param, 0);
        chk("tri.loadupd", param_upd, 1);
        foreach (tri_exp[i]) begin
            wait_upd(n, ok);
            chk($sformatf("tri[%0d].seen", i), ok, 1);
            chk($sformatf("tri[%0d].freq", i), freq_param, tri_exp[i]);
            chk($sformatf("tri[%0d].gap", i), n, 2);
        end
        stop_req = 1'b1;
        tick();
        stop_req = 1'b0;
        chk("tri.stop.busy", busy, 0);
        chk("tri.stop.freq", freq_param, 200);

        // Triangle with lo==hi: load pulse only
        cfg(9, 9, 3, 1, 1'b1);
        add(1, 0, 9, 1, 1, 0);
        for (int c = 0; c < 6; c++) add(0, 0, 9, 0, 1, 0);
        add(0, 1, 9, 0, 0, 0);
        run_tbl("flat");

        // stop_req during STEP
        cfg(10, 40, 10, 3, 1'b0);
        add(1, 0, 10, 1, 1, 0);
        for (int c = 0; c < 3; c++) add(0, 0, 10, 0, 1, 0);
        add(0, 1, 10, 0, 0, 0);
        add(0, 0, 10, 0, 0, 0);
        add(0, 0, 10, 0, 0, 0);
        run_tbl("stopstep");

        // stop_req during DONE
        cfg(5, 5, 1, 1, 1'b0);
        add(1, 0, 5, 1, 1, 0);
        add(0, 0, 5, 0, 1, 0);
        add(0, 0, 5, 0, 1, 0);
        add(0, 1, 5, 0, 0, 0);
        add(0, 0, 5, 0, 0, 0);
        run_tbl("stopdone");

        // Reset mid-DWELL at code 30; start while busy is ignored
        cfg(10, 40, 10, 3, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        cfg(100, 200, 1, 1, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busystart.freq", freq_param, 10);
        chk("busystart.upd", param_upd, 0);
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            tick();
            if (freq_param == 8'd30) ok = 1'b1;
        end
        chk("rstmid.reach30", ok, 1);
        tick();
        chk("rstmid.pre.busy", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("rstmid.freq", freq_param, 0);
        chk("rstmid.busy", busy, 0);
        chk("rstmid.upd", param_upd, 0);
        chk("rstmid.done", done, 0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk("postrst.done", done, 0);
        chk("postrst.freq", freq_param, 0);
        cfg(1, 2, 1, 1, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart.freq", freq_param, 1);
        chk("restart.upd", param_upd, 1);
        chk("restart.busy", busy, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/freq_sweeper.md
FREQ_SWEEPER -- requirements
Module: freq_sweeper

Interface
REQ-001 The block SHALL have parameter PARAM_W, default 8, giving the width of the frequency code.
REQ-002 The block SHALL have parameter DWELL_W, default 16, giving the width of the dwell count.
REQ-003 Port clk_in SHALL be an input, 1 bit: the 1 MHz system clock, and the block's only clock.
REQ-004 Port rst SHALL be an input, 1 bit: reset, asynchronous and active-high.
REQ-005 Port start SHALL be an input, 1 bit: single-cycle request to begin a sweep.
REQ-006 Port stop_req SHALL be an input, 1 bit: abort the sweep in progress.
REQ-007 Port sweep_lo SHALL be an input, PARAM_W bits: lower frequency code.
REQ-008 Port sweep_hi SHALL be an input, PARAM_W bits: upper frequency code.
REQ-009 Port step SHALL be an input, PARAM_W bits: code increment per dwell.
REQ-010 Port dwell SHALL be an input, DWELL_W bits: clk_in cycles spent at each code.
REQ-011 Port mode SHALL be an input, 1 bit: 0 = one-shot up-ramp, 1 = continuous triangle.
REQ-012 Port freq_param SHALL be an output, PARAM_W bits, registered: code driven to the downstream variable-clock generator.
REQ-013 Port param_upd SHALL be an output, 1 bit: one-cycle pulse in the cycle freq_param takes a new value.
REQ-014 Port busy SHALL be an output, 1 bit: high while the FSM is in any state other than IDLE.
REQ-015 Port done SHALL be an output, 1 bit: one-cycle pulse when a one-shot sweep completes.
REQ-016 Port cfg_err SHALL be an output, 1 bit: one-cycle pulse when start is rejected.

Function
REQ-017 The FSM SHALL have exactly the states IDLE, DWELL, STEP and DONE.
REQ-018 In IDLE with start=1 and sweep_lo<=sweep_hi, the block SHALL latch lo, hi, max(step,1), max(dwell,1) and mode, set freq_param=lo, pulse param_upd, set direction up, clear the dwell counter and go to DWELL.
REQ-019 In IDLE with start=1 and sweep_lo>sweep_hi, the block SHALL pulse cfg_err, stay in IDLE and leave freq_param unchanged.
REQ-020 In DWELL, the dwell counter SHALL increment each cycle, and on reaching latched dwell-1 the FSM SHALL go to STEP, so each code is held exactly dwell cycles.
REQ-021 In STEP going up, if freq_param==hi, the block SHALL go to DONE when mode=0, or when mode=1 set direction down, set freq_param=max(hi-step,lo) and return to DWELL.
REQ-022 In STEP going up, if freq_param<hi, the block SHALL set freq_param=min(freq_param+step,hi) and return to DWELL.
REQ-023 In STEP going down, if freq_param==lo, the block SHALL set direction up, set freq_param=min(lo+step,hi) and return to DWELL.
REQ-024 In STEP going down, if freq_param>lo, the block SHALL set freq_param=max(freq_param-step,lo) and return to DWELL.
REQ-025 STEP arithmetic SHALL be PARAM_W+1 bits wide with saturation, so the code never wraps at 0 or 255.
REQ-026 STEP SHALL last exactly one cycle, so the period between updates is dwell+1 cycles.
REQ-027 param_upd SHALL pulse only when freq_param actually changes value, so lo==hi in triangle mode produces no pulses after the load.
REQ-028 DONE SHALL pulse done for one cycle and go to IDLE, and freq_param SHALL hold hi.
REQ-029 stop_req in any non-IDLE state SHALL force IDLE on the next edge, with priority over STEP and DONE transitions: freq_param holds, and param_upd and done do not fire.
REQ-030 start while busy=1 SHALL be ignored, and sweep inputs SHALL be sampled only at an accepted start.
REQ-031 If start and stop_req are both high in IDLE, start SHALL win.

Reset
REQ-032 While rst is high, asynchronously, the block SHALL set freq_param=0, param_upd=0, busy=0, done=0, cfg_err=0, state=IDLE, dwell counter=0 and direction up.
REQ-033 Reset asserted mid-sweep SHALL abandon the sweep with no done pulse.

Structure
REQ-034 A shared package freq_sweep_pkg SHALL hold the state enum, the PARAM_W/DWELL_W defaults and the direction encoding.
REQ-035 The dwell counter SHALL be one sub-module, dwell_timer (clear, enable, terminal-count output), and all other logic SHALL stay in freq_sweeper.

Verification
REQ-036 The bench SHALL drive lo=10, hi=40, step=10, dwell=3, mode=0 and check freq_param 10,20,30,40 each held 3 cycles with STEP between, then a done pulse, busy low, and freq_param=40.
REQ-037 The bench SHALL drive lo=0, hi=255, step=100, mode=1 and check the sequence 0,100,200,255,155,55,0,100,... with no wrap.
REQ-038 The bench SHALL drive lo=50, hi=20 and check a cfg_err pulse, busy=0 and freq_param unchanged.
REQ-039 The bench SHALL drive step=0 and dwell=0 and check behaviour equal to step=1 and dwell=1.
REQ-040 The bench SHALL assert stop_req in the same cycle as STEP and check that freq_param does not change, IDLE is entered next cycle, and done does not fire.
REQ-041 The bench SHALL assert rst mid-DWELL at code 30 and check freq_param=0, busy=0 immediately, and a fresh start accepted after release.
